// File: rtl/shiftreg_rw_pkg.sv
// shiftreg_rw_pkg: shared state type, default widths and division clamp for the shift-register controller.
package shiftreg_rw_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DIV_WIDTH = 6;
  localparam int DEF_CNT_WIDTH = 16;
  function automatic int clamp_div(input int d, input int cnt_width);
    return (d > cnt_width - 1) ? cnt_width - 1 : d;
  endfunction
endpackage

// File: rtl/shiftreg_rw_ctrl_tick.sv
// sr_tick_gen: half-period counter; one-cycle tick every 2**shamt cycles while enabled.
module sr_tick_gen #(
  parameter int CNT_WIDTH = 16,
  parameter int SHW = 4
) (
  input  logic           clk_in,
  input  logic           rst_n,
  input  logic           en,
  input  logic [SHW-1:0] shamt,
  output logic           tick
);
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_top;
  assign w_top = (CNT_WIDTH'(1) << shamt) - CNT_WIDTH'(1);
  assign tick = en && (r_cnt == w_top);
  // Held at zero while idle so the first tick lands exactly H cycles after enable.
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (!en || tick) ? '0 : r_cnt + CNT_WIDTH'(1);
endmodule

// File: rtl/shiftreg_rw_ctrl.sv
// shiftreg_rw_ctrl: serial read/write controller for the chip configuration shift register.
module shiftreg_rw_ctrl
  import shiftreg_rw_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sr_clk,
  output logic                  sr_din,
  output logic                  sr_load,
  input  logic                  sr_dout
);
  localparam int SHW = CNT_WIDTH > 1 ? $clog2(CNT_WIDTH) : 1;
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  state_t r_state, w_next;
  logic [SHW-1:0] r_shamt;
  logic [DATA_WIDTH-1:0] r_sh, r_cap, r_data_out;
  logic [BW-1:0] r_bits;
  logic r_sr_clk, r_sr_din, r_sr_load, r_done;
  logic w_en, w_tick, w_start, w_last_fall, w_load_end;
  assign w_en = r_state != IDLE;
  sr_tick_gen #(.CNT_WIDTH(CNT_WIDTH), .SHW(SHW)) u_tick (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .en(w_en),
    .shamt(r_shamt),
    .tick(w_tick)
  );
  always_comb begin
    w_start = (r_state == IDLE) && start;
    w_last_fall = (r_state == SHIFT) && w_tick && r_sr_clk && (r_bits == BW'(DATA_WIDTH - 1));
    w_load_end = (r_state == LOAD) && w_tick;
    w_next = w_start ? SHIFT : w_last_fall ? LOAD : w_load_end ? IDLE : r_state;
  end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      r_shamt <= '0;
      r_sh <= '0;
      r_cap <= '0;
      r_data_out <= '0;
      r_bits <= '0;
      r_sr_clk <= 1'b0;
      r_sr_din <= 1'b0;
      r_sr_load <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_load_end;
      if (w_load_end) begin
        r_sr_load <= 1'b0;
        r_data_out <= r_cap;
      end
      if (w_start) begin
        r_shamt <= SHW'(clamp_div(int'(div), CNT_WIDTH));
        r_sh <= data_in;
        r_sr_din <= data_in[DATA_WIDTH-1];
        r_bits <= '0;
        r_sr_clk <= 1'b0;
      end else if ((r_state == SHIFT) && w_tick) begin
        r_sr_clk <= !r_sr_clk;
        // Capture on the edge that raises sr_clk; advance sr_din on the edge that lowers it.
        if (!r_sr_clk) r_cap <= {r_cap[DATA_WIDTH-2:0], sr_dout};
        else if (w_last_fall) begin
          r_sr_load <= 1'b1;
          r_sr_din <= 1'b0;
        end else begin
          r_bits <= r_bits + BW'(1);
          r_sh <= r_sh << 1;
          r_sr_din <= r_sh[DATA_WIDTH-2];
        end
      end
    end
  assign busy = w_en;
  assign done = r_done;
  assign data_out = r_data_out;
  assign sr_clk = r_sr_clk;
  assign sr_din = r_sr_din;
  assign sr_load = r_sr_load;
endmodule

// File: tb/tb_shiftreg_rw_ctrl.sv
// tb_shiftreg_rw_ctrl: directed and randomized transfers checked cycle by cycle against the timing formulas.
module tb_shiftreg_rw_ctrl;
  localparam int N = 8;
  logic clk_in = 1'b0;
  logic rst_n = 1'b1;
  logic [5:0] div = '0;
  logic start = 1'b0, start2 = 1'b0, sr_dout = 1'b0;
  logic [N-1:0] data_in = '0;
  logic busy, done, sr_clk, sr_din, sr_load;
  logic [N-1:0] data_out;
  logic busy2, done2, sr_clk2, sr_din2, sr_load2;
  logic [N-1:0] data_out2;
  int checks = 0, failures = 0;
  logic [N-1:0] exp_dout = '0;
  logic sd [0:4095];
  always #5 clk_in = ~clk_in;
  shiftreg_rw_ctrl #(.DATA_WIDTH(N), .DIV_WIDTH(6), .CNT_WIDTH(16)) u_dut (
    .clk_in(clk_in), .rst_n(rst_n), .div(div), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out), .sr_clk(sr_clk), .sr_din(sr_din),
    .sr_load(sr_load), .sr_dout(sr_dout)
  );
  shiftreg_rw_ctrl #(.DATA_WIDTH(N), .DIV_WIDTH(6), .CNT_WIDTH(4)) u_dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .div(div), .start(start2), .data_in(data_in),
    .busy(busy2), .done(done2), .data_out(data_out2), .sr_clk(sr_clk2), .sr_din(sr_din2),
    .sr_load(sr_load2), .sr_dout(1'b0)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step_idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      start = 1'b0;
      chk("idle", {busy, done, sr_clk, sr_din, sr_load, data_out}, {5'b0, exp_dout});
    end
  endtask
  // Caller is #1 after a rising edge; this cycle is cycle 0 of the transfer.
  task automatic xfer(input logic [N-1:0] d, input int dv, input int mode, input bit hold,
                      input bit mid, input int abort_at);
    int h, total, m;
    logic [N-1:0] cap;
    logic e_din;
    h = 1 << (dv > 15 ? 15 : dv);
    total = (2 * N + 1) * h + 1;
    data_in = d;
    div = 6'(dv);
    start = 1'b1;
    for (int c = 1; c <= total; c++) begin
      @(posedge clk_in); #1;
      start = hold;
      if (mid && c == 5) begin
        start = 1'b1;
        div = 6'($urandom_range(0, 63));
        data_in = N'($urandom);
      end
      if (c == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_async", {busy, done, sr_clk, sr_din, sr_load, data_out}, '0);
        repeat (3) begin
          @(posedge clk_in); #1;
          chk("abort_hold", {busy, done, sr_clk, sr_din, sr_load, data_out}, '0);
        end
        rst_n = 1'b1;
        exp_dout = '0;
        return;
      end
      m = (c - 1) / h;
      if (c == total) begin
        for (int k = 0; k < N; k++) cap[N-1-k] = sd[(2 * k + 1) * h];
        exp_dout = cap;
      end
      e_din = (m < 2 * N) ? d[N-1-m/2] : 1'b0;
      chk("cycle", {busy, done, sr_clk, sr_din, sr_load, data_out},
          {1'(c < total), 1'(c == total), 1'(m < 2 * N && m % 2 == 1), e_din, 1'(m == 2 * N), exp_dout});
      sr_dout = (mode == 0) ? sr_din : (mode == 1) ? 1'b1 : 1'($urandom);
      sd[c] = sr_dout;
    end
  endtask
  initial begin
    int cyc;
    #1 rst_n = 1'b0;
    #1;
    chk("reset", {busy, done, sr_clk, sr_din, sr_load, data_out}, '0);
    chk("reset2", {busy2, done2, sr_clk2, sr_din2, sr_load2, data_out2}, '0);
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    step_idle(1);
    xfer(8'hA5, 0, 0, 1'b0, 1'b0, 0);
    chk("loop_a5", data_out, 8'hA5);
    step_idle(1);
    xfer(8'h3C, 2, 1, 1'b0, 1'b0, 0);
    chk("tied_ff", data_out, 8'hFF);
    step_idle(1);
    xfer(8'h96, 0, 0, 1'b0, 1'b1, 0);
    chk("mid_ignored", data_out, 8'h96);
    step_idle(2);
    xfer(8'h5A, 1, 0, 1'b0, 1'b0, 15);
    step_idle(1);
    xfer(8'hC3, 1, 0, 1'b0, 1'b0, 0);
    chk("after_reset", data_out, 8'hC3);
    step_idle(1);
    xfer(8'h81, 0, 2, 1'b1, 1'b0, 0);
    xfer(8'h7E, 1, 0, 1'b0, 1'b0, 0);
    chk("back_to_back", data_out, 8'h7E);
    step_idle(1);
    repeat (6) begin
      xfer(N'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, 1'b0, 0);
      step_idle(1 + int'($urandom_range(0, 2)));
    end
    div = 6'd10;
    start2 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk_in); #1;
      start2 = 1'b0;
      chk("clamp_rise", {busy2, sr_clk2}, {1'b1, 1'(c == 9)});
    end
    cyc = 9;
    while (!done2 && cyc < 300) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    chk("clamp_done_cycle", cyc, 137);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
